fc_batch_sequencer: RTL

Mini-batch controller for the fully-connected training block. Sits between an upstream word-stream source (weights, flattened feature maps, labels) and the FC top module. Drives its mode lines (weight1, weight2, right_answer, enable, bck_prop_start, batch_end) and its external write port. For each batch it optionally loads both weight sets, then runs BATCH_SIZE samples: load input, load label, forward pass, back-propagation. It closes the batch with the batch-end handshake.

---
 rtl/fc_batch_sequencer_pkg.sv | 32 +++
 rtl/fc_batch_sequencer_if.sv | 21 ++
 rtl/fc_word_counter.sv | 26 ++
 rtl/fc_batch_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fc_batch_sequencer_pkg.sv
// Shared definitions for the FC mini-batch sequencer: state encoding and
// default layer geometry with the word counts derived from it.
package fc_batch_sequencer_pkg;

  localparam int FRT_CELL_DEF   = 14;
  localparam int MID_CELL_DEF   = 10;
  localparam int BCK_CELL_DEF   = 5;
  localparam int BATCH_SIZE_DEF = 32;
  localparam int X_WORDS_DEF    = FRT_CELL_DEF * FRT_CELL_DEF;
  localparam int W1_WORDS_DEF   = X_WORDS_DEF * MID_CELL_DEF;
  localparam int W2_WORDS_DEF   = MID_CELL_DEF * BCK_CELL_DEF;
  localparam int ANS_WORDS_DEF  = 10;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LD_W1    = 4'd1,
    ST_LD_W2    = 4'd2,
    ST_LD_X     = 4'd3,
    ST_LD_ANS   = 4'd4,
    ST_FWD      = 4'd5,
    ST_BCK_GO   = 4'd6,
    ST_BCK_WAIT = 4'd7,
    ST_BAT_GO   = 4'd8,
    ST_BAT_WAIT = 4'd9,
    ST_DONE     = 4'd10
  } state_t;

  function automatic logic is_load_state(input state_t s);
    return (s == ST_LD_W1) || (s == ST_LD_W2) || (s == ST_LD_X) || (s == ST_LD_ANS);
  endfunction

endpackage

// File: rtl/fc_batch_sequencer_if.sv
// Upstream word stream plus the FC external write port.
// Handshake: a src word transfers on every rising clk edge where src_valid & src_ready;
// the source holds src_data stable while src_valid is high and src_ready is low.
interface fc_batch_sequencer_if;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;
  logic        ex_we;
  logic [15:0] ex_value;
  logic [15:0] ex_addr;

  modport master (
    output src_valid, src_data,
    input  src_ready, ex_we, ex_value, ex_addr
  );

  modport slave (
    input  src_valid, src_data,
    output src_ready, ex_we, ex_value, ex_addr
  );
endinterface

// File: rtl/fc_word_counter.sv
// Load-word counter: counts accepted beats up to a terminal value, then wraps to 0.
module fc_word_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/fc_batch_sequencer.sv
// Mini-batch controller: optional weight load, then per sample load X / label,
// forward, back-prop; closes the batch with the batch_end handshake.
module fc_batch_sequencer
  import fc_batch_sequencer_pkg::*;
#(
  parameter int FRT_CELL   = FRT_CELL_DEF,
  parameter int MID_CELL   = MID_CELL_DEF,
  parameter int BCK_CELL   = BCK_CELL_DEF,
  parameter int BATCH_SIZE = BATCH_SIZE_DEF,
  parameter int X_WORDS    = FRT_CELL * FRT_CELL,
  parameter int W1_WORDS   = X_WORDS * MID_CELL,
  parameter int W2_WORDS   = MID_CELL * BCK_CELL,
  parameter int ANS_WORDS  = ANS_WORDS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  load_w,
  input  logic                  abort,
  fc_batch_sequencer_if.slave   bus,
  output logic                  weight1,
  output logic                  weight2,
  output logic                  right_answer,
  output logic                  enable,
  output logic                  bck_prop_start,
  output logic                  batch_end,
  input  logic                  all_end,
  input  logic                  fc_bck_prop_end,
  input  logic                  fc_batch_end,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sample_idx,
  output state_t                dbg_state
);

  localparam logic [15:0] W1_LAST   = 16'(W1_WORDS - 1);
  localparam logic [15:0] W2_LAST   = 16'(W2_WORDS - 1);
  localparam logic [15:0] X_LAST    = 16'(X_WORDS - 1);
  localparam logic [15:0] ANS_LAST  = 16'(ANS_WORDS - 1);
  localparam logic [15:0] LAST_SAMP = 16'(BATCH_SIZE - 1);

  state_t      state, state_nxt;
  logic        loading;
  logic        beat;
  logic        beat_last;
  logic        word_tc;
  logic        word_clr;
  logic [15:0] word_cnt;
  logic [15:0] word_term;
  logic        last_sample;

  assign loading     = is_load_state(state);
  assign beat        = bus.src_valid & loading;
  assign beat_last   = beat & word_tc;
  assign last_sample = (sample_idx == LAST_SAMP);
  assign word_clr    = abort | (state == ST_IDLE);

  always_comb begin
    word_term = '0;
    unique case (state)
      ST_LD_W1:  word_term = W1_LAST;
      ST_LD_W2:  word_term = W2_LAST;
      ST_LD_X:   word_term = X_LAST;
      ST_LD_ANS: word_term = ANS_LAST;
      default:   word_term = '0;
    endcase
  end

  fc_word_counter #(.WIDTH(16)) u_word_counter (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (word_clr),
    .en    (beat),
    .term  (word_term),
    .count (word_cnt),
    .tc    (word_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Completion inputs only matter in their own wait state; abort overrides everything.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (start) state_nxt = load_w ? ST_LD_W1 : ST_LD_X;
      ST_LD_W1:    if (beat_last) state_nxt = ST_LD_W2;
      ST_LD_W2:    if (beat_last) state_nxt = ST_LD_X;
      ST_LD_X:     if (beat_last) state_nxt = ST_LD_ANS;
      ST_LD_ANS:   if (beat_last) state_nxt = ST_FWD;
      ST_FWD:      if (all_end) state_nxt = ST_BCK_GO;
      ST_BCK_GO:   state_nxt = ST_BCK_WAIT;
      ST_BCK_WAIT: if (fc_bck_prop_end) state_nxt = last_sample ? ST_BAT_GO : ST_LD_X;
      ST_BAT_GO:   state_nxt = ST_BAT_WAIT;
      ST_BAT_WAIT: if (fc_batch_end) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    weight1        = 1'b0;
    weight2        = 1'b0;
    right_answer   = 1'b0;
    enable         = 1'b0;
    bck_prop_start = 1'b0;
    batch_end      = 1'b0;
    done           = 1'b0;
    busy           = (state != ST_IDLE);
    unique case (state)
      ST_LD_W1:  weight1        = 1'b1;
      ST_LD_W2:  weight2        = 1'b1;
      ST_LD_ANS: right_answer   = 1'b1;
      ST_FWD:    enable         = 1'b1;
      ST_BCK_GO: bck_prop_start = 1'b1;
      ST_BAT_GO: batch_end      = 1'b1;
      ST_DONE:   done           = 1'b1;
      default:   ;
    endcase
  end

  // The write port is combinational so a beat accepted in the abort cycle still lands.
  assign bus.src_ready = loading;
  assign bus.ex_we     = beat;
  assign bus.ex_value  = loading ? bus.src_data : 16'h0000;
  assign bus.ex_addr   = word_cnt;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_idx <= '0;
    end else if (abort) begin
      sample_idx <= '0;
    end else if ((state == ST_IDLE) && start) begin
      sample_idx <= '0;
    end else if ((state == ST_BCK_WAIT) && fc_bck_prop_end && !last_sample) begin
      sample_idx <= sample_idx + 16'd1;
    end
  end

endmodule
